handshake_sender: RTL and testbench



---
 rtl/handshake_sender.sv | 197 +++++++++++++++++++
 tb/tb_handshake_sender.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_sender.sv
// handshake_sender: source-domain half of a toggle request/acknowledge
// clock-domain crossing.
//
// A word offered on write_data/write_valid is captured onto transfer_data
// and announced by toggling transfer_request. The block then waits until
// the resynchronised acknowledge toggle matches the request before it
// accepts the next word. An optional watchdog raises a sticky timeout flag
// when the acknowledge is overdue. The transfer is never aborted, so the
// request/acknowledge parity always stays consistent.
//
// Ports:
//   clock                 source-domain clock
//   resetn                synchronous active-low reset
//   write_data/valid      word offer; accepted when write_ready is high
//   write_ready           high while idle
//   transfer_data         registered word, stable while a transfer is in flight
//   transfer_request      registered request toggle
//   transfer_acknowledge  acknowledge toggle from the destination (asynchronous)
//   busy                  high while waiting for the acknowledge
//   timeout               sticky overdue flag (tied low when TIMEOUT == 0)
//   timeout_clear         single-cycle pulse that clears timeout

// synchronizer: STAGES-deep flip-flop chain that brings an asynchronous
// level into the clock domain.
//   clock/resetn  clock and synchronous active-low reset
//   d_i           asynchronous input level
//   q_o           synchronised level, STAGES cycles late
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the resynchronisation chain.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

module handshake_sender #(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_valid,
  output logic             write_ready,
  output logic [WIDTH-1:0] transfer_data,
  output logic             transfer_request,
  input  logic             transfer_acknowledge,
  output logic             busy,
  output logic             timeout,
  input  logic             timeout_clear
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ack_sync_s;
  logic             accept_s;
  logic             waiting_s;

  synchronizer #(.STAGES(STAGES)) u_ack_sync (
    .clock  (clock),
    .resetn (resetn),
    .d_i    (transfer_acknowledge),
    .q_o    (ack_sync_s)
  );

  // A word is taken only in IDLE; WAIT_ACK ignores the write interface.
  assign accept_s  = (state_q == ST_IDLE) && write_valid;
  // Still waiting: the returned toggle has not yet caught up with ours.
  assign waiting_s = (state_q == ST_WAIT_ACK) && (ack_sync_s != req_q);

  // Next-state logic for the transfer FSM and its data/request registers.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (write_valid) begin
          data_d  = write_data;
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sync_s == req_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request toggle and data registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign write_ready      = (state_q == ST_IDLE);
  assign busy             = (state_q == ST_WAIT_ACK);
  assign transfer_data    = data_q;
  assign transfer_request = req_q;

  if (TIMEOUT > 0) begin : g_timeout
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic          to_set_s;

    // The flag fires on the edge where the counter has already saturated
    // and the acknowledge is still outstanding, i.e. TIMEOUT edges after accept.
    assign to_set_s = waiting_s && (cnt_q == CNT_MAX);

    // Wait counter: cleared on accept, saturating count while waiting.
    always_comb begin
      cnt_d = cnt_q;
      if (accept_s) begin
        cnt_d = '0;
      end else if (waiting_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Sticky flag; a set on the same edge as a clear takes priority.
    always_comb begin
      to_d = to_q;
      if (to_set_s) begin
        to_d = 1'b1;
      end else if (timeout_clear) begin
        to_d = 1'b0;
      end else begin
        to_d = to_q;
      end
    end

    // Counter and timeout flag registers.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        to_q  <= to_d;
      end
    end

    assign timeout = to_q;
  end else begin : g_no_timeout
    logic unused_clear_s;
    assign unused_clear_s = timeout_clear;
    assign timeout        = 1'b0;
  end

endmodule

// File: tb/tb_handshake_sender.sv
// Directed and randomised bench for handshake_sender.
// Expected values come from the transfer rules: an acknowledge raised D
// cycles after the accepting edge keeps the block busy for D+STAGES+1
// samples, loopback gives an accept interval of STAGES+2, and the timeout
// flag rises when the block is still waiting TIMEOUT edges after accept.
module tb_handshake_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   total = 0;
  int   bad   = 0;

  // Main instance: STAGES=2, TIMEOUT=16, acknowledge driven by the bench.
  logic [7:0] a_wd, a_data;
  logic       a_wv, a_ready, a_req, a_ack, a_busy, a_to, a_clr;
  logic       a_par;

  handshake_sender #(.WIDTH(8), .STAGES(2), .TIMEOUT(16)) u_a (
    .clock(clk), .resetn(resetn), .write_data(a_wd), .write_valid(a_wv),
    .write_ready(a_ready), .transfer_data(a_data), .transfer_request(a_req),
    .transfer_acknowledge(a_ack), .busy(a_busy), .timeout(a_to),
    .timeout_clear(a_clr));

  // Loopback instances for timeout boundaries.
  logic [7:0] t3_wd, t3_data, t2_wd, t2_data;
  logic       t3_wv, t3_ready, t3_req, t3_busy, t3_to;
  logic       t2_wv, t2_ready, t2_req, t2_busy, t2_to, t2_clr;

  handshake_sender #(.WIDTH(8), .STAGES(2), .TIMEOUT(3)) u_t3 (
    .clock(clk), .resetn(resetn), .write_data(t3_wd), .write_valid(t3_wv),
    .write_ready(t3_ready), .transfer_data(t3_data), .transfer_request(t3_req),
    .transfer_acknowledge(t3_req), .busy(t3_busy), .timeout(t3_to),
    .timeout_clear(1'b0));

  handshake_sender #(.WIDTH(8), .STAGES(2), .TIMEOUT(2)) u_t2 (
    .clock(clk), .resetn(resetn), .write_data(t2_wd), .write_valid(t2_wv),
    .write_ready(t2_ready), .transfer_data(t2_data), .transfer_request(t2_req),
    .transfer_acknowledge(t2_req), .busy(t2_busy), .timeout(t2_to),
    .timeout_clear(t2_clr));

  // Loopback throughput instances, STAGES = 1..4, no timeout.
  logic [7:0] g_wd [1:4];
  logic [7:0] g_data [1:4];
  logic       g_wv [1:4];
  logic       g_ready [1:4];
  logic       g_req [1:4];
  logic       g_busy [1:4];
  logic       g_to [1:4];

  for (genvar g = 1; g <= 4; g++) begin : g_loop
    handshake_sender #(.WIDTH(8), .STAGES(g), .TIMEOUT(0)) u_g (
      .clock(clk), .resetn(resetn), .write_data(g_wd[g]), .write_valid(g_wv[g]),
      .write_ready(g_ready[g]), .transfer_data(g_data[g]),
      .transfer_request(g_req[g]), .transfer_acknowledge(g_req[g]),
      .busy(g_busy[g]), .timeout(g_to[g]), .timeout_clear(1'b0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    a_wv = 1'b0; a_wd = 8'h00; a_ack = 1'b0; a_clr = 1'b0; a_par = 1'b0;
    t3_wv = 1'b0; t3_wd = 8'h00; t2_wv = 1'b0; t2_wd = 8'h00; t2_clr = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      g_wv[s] = 1'b0;
      g_wd[s] = 8'h00;
    end
    step();
    step();
    resetn = 1'b1;
  endtask

  // One transfer on u_a; the bench returns the acknowledge dly cycles after accept.
  task automatic a_transfer(input logic [7:0] d, input int dly, input bit auto_clr);
    int n;
    bit exp_to;
    n = 0;
    while (!a_ready && n < 100) begin
      step();
      n++;
    end
    chk("a_ready_wait", {31'd0, a_ready}, 32'd1);
    a_wd = d;
    a_wv = 1'b1;
    step();
    a_par = ~a_par;
    chk("a_acc_data", {24'd0, a_data}, {24'd0, d});
    chk("a_acc_req", {31'd0, a_req}, {31'd0, a_par});
    n = 0;
    while (a_busy && n < 100) begin
      chk("a_to_run", {31'd0, a_to}, (n >= 16) ? 32'd1 : 32'd0);
      chk("a_hold", {24'd0, a_data}, {24'd0, d});
      if (n == dly) a_ack = a_par;
      a_wd = 8'($urandom);
      step();
      n++;
    end
    a_wv = 1'b0;
    chk("a_busy_len", n, dly + 3);
    exp_to = (dly + 2 >= 16);
    chk("a_to_end", {31'd0, a_to}, {31'd0, exp_to});
    chk("a_req_end", {31'd0, a_req}, {31'd0, a_par});
    chk("a_ready_end", {31'd0, a_ready}, 32'd1);
    if (auto_clr && exp_to) begin
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      chk("a_to_clr", {31'd0, a_to}, 32'd0);
    end
  endtask

  // Loopback throughput: three words with write_valid held high.
  task automatic thr(input int s);
    logic [7:0] words [3];
    logic       pre;
    int acc, n, last;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    acc = 0; n = 0; last = 0;
    g_wv[s] = 1'b1;
    g_wd[s] = words[0];
    while (acc < 3 && n < 60) begin
      pre = g_ready[s];
      step();
      n++;
      if (pre) begin
        if (acc > 0) chk("thr_interval", n - last, s + 2);
        last = n;
        chk("thr_data", {24'd0, g_data[s]}, {24'd0, words[acc]});
        chk("thr_req", {31'd0, g_req[s]}, (acc % 2 == 0) ? 32'd1 : 32'd0);
        chk("thr_to", {31'd0, g_to[s]}, 32'd0);
        acc++;
        if (acc < 3) g_wd[s] = words[acc];
        else g_wv[s] = 1'b0;
      end
    end
    g_wv[s] = 1'b0;
    chk("thr_accepts", acc, 3);
  endtask

  initial begin
    // 1. Reset values.
    do_reset();
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_req", {31'd0, a_req}, 32'd0);
    chk("rst_data", {24'd0, a_data}, 32'd0);
    chk("rst_to", {31'd0, a_to}, 32'd0);
    step();
    chk("rst_ready2", {31'd0, a_ready}, 32'd1);
    chk("rst_busy2", {31'd0, a_busy}, 32'd0);
    for (int s = 1; s <= 4; s++) begin
      chk("rst_g_ready", {31'd0, g_ready[s]}, 32'd1);
      chk("rst_g_req", {31'd0, g_req[s]}, 32'd0);
    end

    // 2. Loopback single word on STAGES=2.
    g_wd[2] = 8'hA5;
    g_wv[2] = 1'b1;
    step();
    g_wv[2] = 1'b0;
    chk("lb_data", {24'd0, g_data[2]}, 32'hA5);
    chk("lb_req", {31'd0, g_req[2]}, 32'd1);
    chk("lb_ready_e0", {31'd0, g_ready[2]}, 32'd0);
    chk("lb_busy_e0", {31'd0, g_busy[2]}, 32'd1);
    step();
    chk("lb_ready_e1", {31'd0, g_ready[2]}, 32'd0);
    step();
    chk("lb_ready_e2", {31'd0, g_ready[2]}, 32'd0);
    step();
    chk("lb_ready_e3", {31'd0, g_ready[2]}, 32'd1);
    chk("lb_busy_e3", {31'd0, g_busy[2]}, 32'd0);
    chk("lb_data_hold", {24'd0, g_data[2]}, 32'hA5);

    // 3. Throughput for STAGES 1..4.
    do_reset();
    for (int s = 1; s <= 4; s++) thr(s);

    // 4. Timeout: acknowledge returned 20 cycles after accept.
    do_reset();
    a_transfer(8'h5C, 20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to_sticky", {31'd0, a_to}, 32'd1);
    end
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("to_cleared", {31'd0, a_to}, 32'd0);

    // Randomised transfers against the timing model.
    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int k = 0; k < gap; k++) begin
        step();
        chk("rnd_idle", {31'd0, a_ready}, 32'd1);
      end
      a_transfer(8'($urandom), int'($urandom_range(0, 20)), 1'b1);
    end

    // 5. Timeout boundaries in loopback.
    do_reset();
    t3_wd = 8'h3C; t2_wd = 8'h2C;
    t3_wv = 1'b1; t2_wv = 1'b1;
    step();
    t3_wv = 1'b0; t2_wv = 1'b0;
    chk("tb_t3_data", {24'd0, t3_data}, 32'h3C);
    chk("tb_t2_to_e0", {31'd0, t2_to}, 32'd0);
    step();
    chk("tb_t2_to_e1", {31'd0, t2_to}, 32'd0);
    t2_clr = 1'b1;
    step();
    t2_clr = 1'b0;
    chk("tb_t2_to_e2", {31'd0, t2_to}, 32'd1);
    chk("tb_t3_to_e2", {31'd0, t3_to}, 32'd0);
    step();
    chk("tb_t2_to_e3", {31'd0, t2_to}, 32'd1);
    chk("tb_t3_ready_e3", {31'd0, t3_ready}, 32'd1);
    chk("tb_t2_ready_e3", {31'd0, t2_ready}, 32'd1);
    chk("tb_t3_to_e3", {31'd0, t3_to}, 32'd0);
    t2_clr = 1'b1;
    step();
    t2_clr = 1'b0;
    chk("tb_t2_clr", {31'd0, t2_to}, 32'd0);
    chk("tb_t3_to_end", {31'd0, t3_to}, 32'd0);

    // 6. Reset mid-transfer, then a spurious acknowledge in IDLE.
    do_reset();
    a_wd = 8'h77;
    a_wv = 1'b1;
    step();
    a_wv = 1'b0;
    chk("mid_busy", {31'd0, a_busy}, 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_ready", {31'd0, a_ready}, 32'd1);
    chk("mid_busy0", {31'd0, a_busy}, 32'd0);
    chk("mid_req", {31'd0, a_req}, 32'd0);
    a_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("spur_ready", {31'd0, a_ready}, 32'd1);
      chk("spur_busy", {31'd0, a_busy}, 32'd0);
      chk("spur_req", {31'd0, a_req}, 32'd0);
      chk("spur_data", {24'd0, a_data}, 32'd0);
      chk("spur_to", {31'd0, a_to}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
